// File: rtl/fp_pkg.sv
// Shared floating-point constants and the normalizer state encoding.
package fp_pkg;

  localparam int EXP_W      = 8;
  localparam int MANT_W     = 28;
  localparam int HIDDEN_BIT = 26;
  localparam int CARRY_BIT  = 27;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage

// File: rtl/normalizer_lzc28.sv
// Combinational 28-bit leading-zero counter; an all-zero input yields 28.
module lzc28 (
  input  logic [27:0] i_val,
  output logic [4:0]  o_cnt
);

  logic w_found;

  always_comb begin
    o_cnt   = 5'd28;
    w_found = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (!w_found && i_val[i]) begin
        o_cnt   = 5'(27 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/normalizer.sv
// Post-adder normalizer: iteratively shifts the sum mantissa until the leading
// one sits at the hidden-bit position, adjusting the exponent to match.
module normalizer
  import fp_pkg::*;
#(
  parameter int STEP   = 4,
  parameter int MANT_W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        exp,
  input  logic [MANT_W-1:0] mantis,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        exp_out,
  output logic [MANT_W-1:0] mantis_out,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid is held with stable data until that edge.

  localparam logic [7:0] STEP_E = 8'(STEP);

  norm_state_t       r_state;
  logic [7:0]        r_e;
  logic [MANT_W-1:0] r_m;
  logic              r_ovf;

  logic [4:0]        w_lzc;
  logic [7:0]        w_z;
  logic [7:0]        w_k;
  logic [7:0]        w_e_lim;
  logic [8:0]        w_inc;
  logic [MANT_W-1:0] w_shr;
  logic [MANT_W-1:0] w_shl;

  lzc28 u_lzc (
    .i_val (r_m),
    .o_cnt (w_lzc)
  );

  // Shift distance is bounded by the zeros above the hidden bit, the per-cycle
  // limit, and the exponent so it never drops below 1 during a shift.
  always_comb begin
    w_z     = {3'b000, w_lzc} - 8'd1;
    w_e_lim = r_e - 8'd1;
    w_k     = w_z;
    if (STEP_E < w_k)  w_k = STEP_E;
    if (w_e_lim < w_k) w_k = w_e_lim;
    w_shl   = r_m << w_k;
    w_shr   = {1'b0, r_m[MANT_W-1:2], r_m[1] | r_m[0]};
    w_inc   = {1'b0, r_e} + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_e     <= '0;
      r_m     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_e     <= exp;
            r_m     <= mantis;
            r_ovf   <= 1'b0;
            r_state <= NORM;
          end
        end
        NORM: begin
          if (r_m[CARRY_BIT]) begin
            if (w_inc >= {1'b0, EXP_MAX}) begin
              r_e   <= EXP_MAX;
              r_m   <= '0;
              r_ovf <= 1'b1;
            end else begin
              r_e <= w_inc[7:0];
              r_m <= w_shr;
            end
            r_state <= DONE;
          end else if (r_m == '0) begin
            r_e     <= '0;
            r_state <= DONE;
          end else if (r_m[HIDDEN_BIT]) begin
            r_state <= DONE;
          end else if (r_e <= 8'd1) begin
            r_e     <= '0;
            r_state <= DONE;
          end else begin
            r_m     <= w_shl;
            r_e     <= r_e - w_k;
            r_state <= NORM;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign exp_out    = r_e;
  assign mantis_out = r_m;
  assign overflow   = r_ovf;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_normalizer.sv
// Directed bench for the normalizer; instance 0 uses STEP=1, instance 1 STEP=4.
module tb_normalizer;
  import fp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [7:0]  exp_in     [2];
  logic [27:0] mantis     [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [7:0]  exp_out    [2];
  logic [27:0] mantis_out [2];
  logic        overflow   [2];
  logic [1:0]  dbg_state  [2];

  int n_cmp;
  int n_bad;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  normalizer #(.STEP(1), .MANT_W(28)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .exp(exp_in[0]), .mantis(mantis[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .exp_out(exp_out[0]), .mantis_out(mantis_out[0]),
    .overflow(overflow[0]), .dbg_state(dbg_state[0])
  );

  normalizer #(.STEP(4), .MANT_W(28)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .exp(exp_in[1]), .mantis(mantis[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .exp_out(exp_out[1]), .mantis_out(mantis_out[1]),
    .overflow(overflow[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_cmp++;
    if (obs !== expd) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand, measures accept-to-out_valid latency, checks the
  // result, then completes the output handshake.
  task automatic run_op(input int u, input string tag, input logic [7:0] e,
                        input logic [27:0] m, input int lat,
                        input logic [7:0] e_exp, input logic [27:0] m_exp,
                        input logic ovf_exp);
    int cnt;
    check({tag, ".in_ready"}, 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1;
    exp_in[u]   = e;
    mantis[u]   = m;
    tick();
    in_valid[u] = 1'b0;
    exp_in[u]   = '0;
    mantis[u]   = '0;
    cnt = 1;
    while (!out_valid[u] && cnt < 100) begin
      tick();
      cnt++;
    end
    check({tag, ".latency"}, 32'(cnt), 32'(lat));
    check({tag, ".exp_out"}, 32'(exp_out[u]), 32'(e_exp));
    check({tag, ".mantis_out"}, 32'(mantis_out[u]), 32'(m_exp));
    check({tag, ".overflow"}, 32'(overflow[u]), 32'(ovf_exp));
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    check({tag, ".back_idle"}, 32'(in_ready[u]), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      exp_in[i]    = '0;
      mantis[i]    = '0;
      out_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    for (int u = 0; u < 2; u++) begin
      check("rst.in_ready", 32'(in_ready[u]), 32'd1);
      check("rst.out_valid", 32'(out_valid[u]), 32'd0);
      check("rst.exp_out", 32'(exp_out[u]), 32'd0);
      check("rst.mantis_out", 32'(mantis_out[u]), 32'd0);
      check("rst.overflow", 32'(overflow[u]), 32'd0);
    end

    run_op(0, "s1_lz4",     8'd100, 28'h0400000, 6, 8'd96,  28'h4000000, 1'b0);
    run_op(1, "s4_lz4",     8'd100, 28'h0400000, 3, 8'd96,  28'h4000000, 1'b0);
    run_op(1, "s4_carry",   8'd100, 28'h8000001, 2, 8'd101, 28'h4000001, 1'b0);
    run_op(1, "s4_ovf",     8'd254, 28'h8000000, 2, 8'd255, 28'h0000000, 1'b1);
    run_op(1, "s4_denorm",  8'd3,   28'h0000010, 3, 8'd0,   28'h0000040, 1'b0);
    run_op(1, "s4_zero",    8'd77,  28'h0000000, 2, 8'd0,   28'h0000000, 1'b0);
    run_op(1, "s4_norm",    8'd50,  28'h4000005, 2, 8'd50,  28'h4000005, 1'b0);
    run_op(1, "s4_lz26",    8'd100, 28'h0000001, 9, 8'd74,  28'h4000000, 1'b0);
    run_op(0, "s1_e1",      8'd1,   28'h0100000, 2, 8'd0,   28'h0100000, 1'b0);
    run_op(0, "s1_carry",   8'd7,   28'h8000002, 2, 8'd8,   28'h4000001, 1'b0);

    // Result held in DONE while downstream stalls
    in_valid[1] = 1'b1;
    exp_in[1]   = 8'd20;
    mantis[1]   = 28'h1000000;
    tick();
    in_valid[1] = 1'b0;
    for (int i = 0; i < 2; i++) tick();
    check("hold.enter", 32'(out_valid[1]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.out_valid", 32'(out_valid[1]), 32'd1);
      check("hold.in_ready", 32'(in_ready[1]), 32'd0);
      check("hold.exp_out", 32'(exp_out[1]), 32'd18);
      check("hold.mantis_out", 32'(mantis_out[1]), 32'h4000000);
    end
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    check("hold.release_idle", 32'(dbg_state[1]), 32'(IDLE));
    check("hold.release_ovalid", 32'(out_valid[1]), 32'd0);

    // Reset in the middle of a multi-cycle normalization
    in_valid[1] = 1'b1;
    exp_in[1]   = 8'd100;
    mantis[1]   = 28'h0000001;
    tick();
    in_valid[1] = 1'b0;
    tick();
    check("abort.in_norm", 32'(dbg_state[1]), 32'(NORM));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort.state", 32'(dbg_state[1]), 32'(IDLE));
    check("abort.out_valid", 32'(out_valid[1]), 32'd0);
    check("abort.exp_out", 32'(exp_out[1]), 32'd0);
    check("abort.mantis_out", 32'(mantis_out[1]), 32'd0);
    check("abort.overflow", 32'(overflow[1]), 32'd0);
    run_op(1, "post_abort", 8'd40, 28'h2000003, 3, 8'd39, 28'h4000006, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
